// File: rtl/exc_seq.sv
// Exception sequencer: latches masked cause requests, services the lowest pending
// index via SAVE(EPC) -> READ(vector byte) -> WAIT -> JUMP(PC) -> DONE, then back to IDLE.
module exc_seq #(
  parameter int DATA_W     = 32,
  parameter int NUM_CAUSES = 4,
  parameter int CODE_W     = 2,
  parameter int VEC_BASE   = 253,
  parameter int VEC_STRIDE = 1,
  parameter int PC_OFFSET  = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_CAUSES-1:0] cause_req,
  input  logic [NUM_CAUSES-1:0] cause_mask,
  input  logic [DATA_W-1:0]     pc_in,
  input  logic [7:0]            mem_rdata,
  output logic                  stall_out,
  output logic                  busy,
  output logic [CODE_W-1:0]     cause_code,
  output logic                  epc_write,
  output logic [DATA_W-1:0]     epc_value,
  output logic                  mem_rd,
  output logic [DATA_W-1:0]     mem_addr,
  output logic                  pc_write,
  output logic [DATA_W-1:0]     pc_value,
  output logic                  done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SAVE = 3'd1,
    S_READ = 3'd2,
    S_WAIT = 3'd3,
    S_JUMP = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t                  state_q, state_d;
  logic [NUM_CAUSES-1:0]   pending_q, pending_d;
  logic [CODE_W-1:0]       code_q, code_d;
  logic [7:0]              vec_q, vec_d;
  logic [CODE_W-1:0]       sel;
  logic [NUM_CAUSES-1:0]   code_onehot;
  logic [NUM_CAUSES-1:0]   clr;
  logic [DATA_W-1:0]       vec_addr;

  // Lowest pending index wins; onehot of the cause in service drives the clear.
  always_comb begin
    sel         = '0;
    code_onehot = '0;
    for (int i = NUM_CAUSES - 1; i >= 0; i--) begin
      if (pending_q[i]) sel = CODE_W'(i);
    end
    for (int i = 0; i < NUM_CAUSES; i++) begin
      code_onehot[i] = (code_q == CODE_W'(i));
    end
  end

  assign vec_addr = DATA_W'(VEC_BASE) + DATA_W'(code_q) * DATA_W'(VEC_STRIDE);

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    vec_d   = vec_q;
    clr     = '0;
    case (state_q)
      S_IDLE: begin
        if (|pending_q) begin
          state_d = S_SAVE;
          code_d  = sel;
        end
      end
      S_SAVE: state_d = S_READ;
      S_READ: state_d = S_WAIT;
      S_WAIT: begin
        state_d = S_JUMP;
        vec_d   = mem_rdata;
      end
      S_JUMP: begin
        state_d = S_DONE;
        clr     = code_onehot;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // New requests are OR-ed in after the clear so a same-cycle re-request survives.
    pending_d = (pending_q & ~clr) | (cause_req & ~cause_mask);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      code_q    <= '0;
      vec_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      code_q    <= code_d;
      vec_q     <= vec_d;
    end
  end

  // Moore outputs. stall_out rises the cycle after a request is latched and holds
  // the main FSM (and therefore pc_in) until the sequencer is idle with nothing pending.
  always_comb begin
    busy       = (state_q != S_IDLE);
    stall_out  = busy | (|pending_q);
    cause_code = '0;
    epc_write  = 1'b0;
    epc_value  = '0;
    mem_rd     = 1'b0;
    mem_addr   = '0;
    pc_write   = 1'b0;
    pc_value   = '0;
    done       = 1'b0;
    if (busy) cause_code = code_q;
    case (state_q)
      S_SAVE: begin
        epc_write = 1'b1;
        epc_value = pc_in - DATA_W'(PC_OFFSET);
      end
      S_READ: begin
        mem_rd   = 1'b1;
        mem_addr = vec_addr;
      end
      S_WAIT: mem_addr = vec_addr;
      S_JUMP: begin
        pc_write = 1'b1;
        pc_value = {{(DATA_W-8){1'b0}}, vec_q};
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule
